// File: rtl/int_ack_seq.sv
// int_ack_seq -- two-pulse interrupt acknowledge sequencer.
//
// Recognises an interrupt at an instruction boundary and issues two
// acknowledge pulses to the interrupt controller, separated by ACK_GAP
// idle cycles. It then waits up to SEL_TIMEOUT cycles for the controller
// to present a vector code. The vector selects a 4-byte table entry, which
// is fetched as two 16-bit reads (new IP, then new CS). A missing vector
// aborts the sequence with a spurious pulse.
//
// Ports:
//   iClk, iRst        clock (rising edge), asynchronous active-high reset
//   iInt, iIf,        interrupt request, CPU interrupt-enable flag and
//   iBoundary         instruction boundary; all three start a sequence
//   oIntAck           single-cycle acknowledge pulse (issued twice)
//   iSel, iData[7:0]  controller strobe and vector code
//   oMemReq           read request, held until iMemAck
//   oMemAddr[19:0]    read address (vector table entry)
//   iMemAck,          read completion strobe and read data
//   iMemData[15:0]
//   oBusy             sequence in progress (every state except idle)
//   oDone             single-cycle pulse; oVector/oNewIp/oNewCs valid
//   oVector[7:0]      captured vector code, held until the next capture
//   oNewIp, oNewCs    fetched IP/CS, held until the next completed sequence
//   oSpurious         single-cycle pulse: no vector arrived before timeout
module int_ack_seq #(
  parameter int unsigned ACK_GAP     = 2,
  parameter int unsigned SEL_TIMEOUT = 8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iInt,
  input  logic        iIf,
  input  logic        iBoundary,
  output logic        oIntAck,
  input  logic        iSel,
  input  logic [7:0]  iData,
  output logic        oMemReq,
  output logic [19:0] oMemAddr,
  input  logic        iMemAck,
  input  logic [15:0] iMemData,
  output logic        oBusy,
  output logic        oDone,
  output logic [7:0]  oVector,
  output logic [15:0] oNewIp,
  output logic [15:0] oNewCs,
  output logic        oSpurious
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK1,
    S_GAP,
    S_ACK2,
    S_WAIT_SEL,
    S_RD_IP,
    S_RD_CS,
    S_DONE
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(ACK_GAP - 1);
  localparam logic [7:0] SEL_LAST = 8'(SEL_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  sel_cnt_q, sel_cnt_d;
  logic [7:0]  vector_q, vector_d;
  logic [15:0] ip_hold_q, ip_hold_d;
  logic [15:0] cs_hold_q, cs_hold_d;
  logic [15:0] new_ip_q, new_ip_d;
  logic [15:0] new_cs_q, new_cs_d;
  logic        spurious_q, spurious_d;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      gap_cnt_q  <= '0;
      sel_cnt_q  <= '0;
      vector_q   <= '0;
      ip_hold_q  <= '0;
      cs_hold_q  <= '0;
      new_ip_q   <= '0;
      new_cs_q   <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      sel_cnt_q  <= sel_cnt_d;
      vector_q   <= vector_d;
      ip_hold_q  <= ip_hold_d;
      cs_hold_q  <= cs_hold_d;
      new_ip_q   <= new_ip_d;
      new_cs_q   <= new_cs_d;
      spurious_q <= spurious_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    sel_cnt_d  = sel_cnt_q;
    vector_d   = vector_q;
    ip_hold_d  = ip_hold_q;
    cs_hold_d  = cs_hold_q;
    new_ip_d   = new_ip_q;
    new_cs_d   = new_cs_q;
    spurious_d = 1'b0;
    oIntAck    = 1'b0;
    oMemReq    = 1'b0;
    oMemAddr   = '0;
    oDone      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iInt && iIf && iBoundary) begin
          state_d = S_ACK1;
        end
      end
      S_ACK1: begin
        oIntAck   = 1'b1;
        gap_cnt_d = '0;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_ACK2;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      S_ACK2: begin
        oIntAck   = 1'b1;
        sel_cnt_d = '0;
        state_d   = S_WAIT_SEL;
      end
      S_WAIT_SEL: begin
        if (iSel) begin
          vector_d = iData;
          state_d  = S_RD_IP;
        end else if (sel_cnt_q == SEL_LAST) begin
          // Spurious is registered so its pulse lands in the first idle cycle.
          sel_cnt_d  = '0;
          spurious_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          sel_cnt_d = sel_cnt_q + 8'd1;
        end
      end
      S_RD_IP: begin
        oMemReq  = 1'b1;
        oMemAddr = {10'h000, vector_q, 2'b00};
        if (iMemAck) begin
          ip_hold_d = iMemData;
          state_d   = S_RD_CS;
        end
      end
      S_RD_CS: begin
        oMemReq  = 1'b1;
        oMemAddr = {10'h000, vector_q, 2'b10};
        if (iMemAck) begin
          cs_hold_d = iMemData;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        oDone    = 1'b1;
        new_ip_d = ip_hold_q;
        new_cs_d = cs_hold_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The DONE cycle already presents the freshly fetched pair; the output
  // registers take it on the same edge that leaves DONE, so the values hold
  // afterwards without a one-cycle lag behind oDone.
  assign oNewIp    = (state_q == S_DONE) ? ip_hold_q : new_ip_q;
  assign oNewCs    = (state_q == S_DONE) ? cs_hold_q : new_cs_q;
  assign oVector   = vector_q;
  assign oBusy     = (state_q != S_IDLE);
  assign oSpurious = spurious_q;

endmodule

// File: doc/int_ack_seq.md
INT_ACK_SEQ -- requirements
Module: int_ack_seq

Interface
REQ-001 Parameter ACK_GAP, default 2: idle cycles between the two acknowledge pulses (range 1..15).
REQ-002 Parameter SEL_TIMEOUT, default 8: WAIT_SEL cycles allowed before abort (range 1..255).
REQ-003 Ports SHALL be exactly as follows: one clock; reset is asynchronous and active-high (iClk, iRst).
REQ-004 iClk  in  1  system clock, all state on rising edge.
REQ-005 iRst  in  1  asynchronous active-high reset.
REQ-006 iInt  in  1  interrupt request level from interrupt controller.
REQ-007 iIf  in  1  CPU interrupt-enable flag.
REQ-008 iBoundary  in  1  CPU at instruction boundary, may accept interrupt.
REQ-009 oIntAck  out  1  single-cycle acknowledge pulse to interrupt controller.
REQ-010 iSel  in  1  controller drives iData this cycle.
REQ-011 iData  in  8  vector code from controller.
REQ-012 oMemReq  out  1  memory read request, held until acknowledged.
REQ-013 oMemAddr  out  20  read address.
REQ-014 iMemAck  in  1  single-cycle read completion; iMemData valid this cycle.
REQ-015 iMemData  in  16  read data.
REQ-016 oBusy  out  1  sequence in progress; CPU stalls fetch.
REQ-017 oDone  out  1  single-cycle pulse: oVector/oNewIp/oNewCs valid.
REQ-018 oVector  out  8  captured vector; oNewIp out 16; oNewCs out 16; held until next capture.
REQ-019 oSpurious  out  1  single-cycle pulse: sequence aborted on timeout.

Function
REQ-020 States: IDLE, ACK1, GAP, ACK2, WAIT_SEL, RD_IP, RD_CS, DONE.
REQ-021 IDLE -> ACK1 when iInt & iIf & iBoundary in the same cycle; otherwise stay.
REQ-022 ACK1: oIntAck=1 for exactly one cycle; -> GAP; any iSel/iData in ACK1 or GAP ignored.
REQ-023 GAP: 4-bit counter, stays ACK_GAP cycles, then -> ACK2.
REQ-024 ACK2: oIntAck=1 for one cycle; -> WAIT_SEL; timeout counter cleared.
REQ-025 WAIT_SEL: on iSel=1 capture iData into oVector, -> RD_IP; else increment counter; at SEL_TIMEOUT cycles without iSel, pulse oSpurious next cycle, -> IDLE, oVector unchanged.
REQ-026 RD_IP: oMemReq=1, oMemAddr={10'h000, oVector, 2'b00}; on iMemAck latch iMemData into IP holding register, -> RD_CS.
REQ-027 RD_CS: oMemReq=1, oMemAddr={10'h000, oVector, 2'b10}; on iMemAck latch iMemData into CS holding register, -> DONE.
REQ-028 oMemReq SHALL drop the cycle after iMemAck is seen; between RD_IP and RD_CS oMemReq may remain high with address changing only after the ack cycle.
REQ-029 DONE: oNewIp/oNewCs updated from holding registers, oDone=1 for one cycle, -> IDLE.
REQ-030 oBusy=1 in every state except IDLE, including the DONE cycle.
REQ-031 iInt, iIf, iBoundary ignored outside IDLE; iInt deassertion mid-sequence does not abort.
REQ-032 iMemAck outside RD_IP/RD_CS ignored; iSel outside WAIT_SEL ignored.
REQ-033 Back-to-back: from DONE the next IDLE cycle may start a new sequence; minimum IDLE dwell one cycle.
REQ-034 Memory wait unbounded; no timeout in RD_IP/RD_CS.

Reset
REQ-035 iRst asserted: state IDLE immediately; oIntAck, oMemReq, oBusy, oDone, oSpurious = 0; oMemAddr = 0; oVector=0, oNewIp=0, oNewCs=0; counters 0.
REQ-036 Reset mid-sequence (any state) SHALL abandon it with no oDone/oSpurious pulse; outstanding memory read discarded.
REQ-037 Release of iRst takes effect on the next iClk edge; first possible ACK1 is one cycle after a qualifying IDLE cycle.

Verification
REQ-038 iInt=iIf=iBoundary=1, ACK_GAP=2, iSel with iData=8'h09 one cycle after ACK2 -> oIntAck pulses 3 cycles apart, oMemAddr 20'h00024 then 20'h00026, mem returns 16'h1234/16'hF000 -> oDone with oVector=09, oNewIp=1234, oNewCs=F000.
REQ-039 iIf=0 with iInt=1 for 20 cycles -> no oIntAck, oBusy stays 0.
REQ-040 No iSel after ACK2, SEL_TIMEOUT=8 -> oSpurious pulse, no memory request, return to IDLE, oVector unchanged.
REQ-041 iSel=1 with iData=8'h55 during ACK1 and GAP, then iData=8'h08 in WAIT_SEL -> oVector=08, addresses 20'h00020/20'h00022.
REQ-042 iRst asserted while oMemReq=1 in RD_CS, late iMemAck after release -> outputs zero, no oDone, state IDLE.
REQ-043 iMemAck delayed 5 cycles each read -> oMemReq and oMemAddr stable throughout, oDone exactly once.
